// File: rtl/ni_inject_pkg.sv
// rtl/ni_inject_pkg.sv - shared flit constants, head layout and width helpers for the injection stage
package ni_inject_pkg;

  typedef enum logic [1:0] {
    FLIT_BODY = 2'b00,
    FLIT_HEAD = 2'b01,
    FLIT_TAIL = 2'b10
  } flit_type_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } inj_state_e;

  localparam int HEAD_FIELD_W  = 4;
  localparam int HEAD_DSTX_LSB = 0;
  localparam int HEAD_DSTY_LSB = 4;
  localparam int HEAD_SRCX_LSB = 8;
  localparam int HEAD_SRCY_LSB = 12;

  // Index width that stays at least one bit wide for single-entry structures.
  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Bits needed to hold every value 0..n inclusive.
  function automatic int cnt_width(input int n);
    return (n > 0) ? $clog2(n + 1) : 1;
  endfunction

endpackage

// File: rtl/ni_fifo.sv
// rtl/ni_fifo.sv - synchronous FIFO with full/empty flags and asynchronous active-low reset
module ni_fifo
  import ni_inject_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = clog2_min1(DEPTH);
  localparam int CW = cnt_width(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             do_push;
  logic             do_pop;

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);
  assign rdata = mem[rd_ptr];

  // A full FIFO may still take a word when the same cycle frees a slot.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= next_ptr(wr_ptr);
      if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
      if (do_push && !do_pop)      count <= count + CW'(1);
      else if (!do_push && do_pop) count <= count - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/ni_inject.sv
// rtl/ni_inject.sv - local-port injection: buffers core words, allocates a drained VC,
// emits head/body/tail flits and tracks per-VC router buffer credits
module ni_inject
  import ni_inject_pkg::*;
#(
  parameter int ROUTERID  = 0,
  parameter int MY_XPOS   = 0,
  parameter int MY_YPOS   = 0,
  parameter int DATAW     = 64,
  parameter int NVCH      = 2,
  parameter int BUFDEPTH  = 4,
  parameter int FIFODEPTH = 4
) (
  input  logic                        clk,
  input  logic                        rst_,
  input  logic [DATAW-3:0]            core_data,
  input  logic                        core_sop,
  input  logic                        core_eop,
  input  logic [3:0]                  core_dst_x,
  input  logic [3:0]                  core_dst_y,
  input  logic                        core_valid,
  output logic                        core_ready,
  output logic [DATAW-1:0]            odata,
  output logic                        ovalid,
  output logic [clog2_min1(NVCH)-1:0] ovch,
  input  logic [NVCH-1:0]             iack,
  input  logic [NVCH-1:0]             ilck
);

  localparam int VCW = clog2_min1(NVCH);
  localparam int CRW = cnt_width(BUFDEPTH);
  localparam int PW  = DATAW - 2;
  localparam logic [CRW-1:0] CRED_FULL = CRW'(BUFDEPTH);

  typedef struct packed {
    logic          sop;
    logic          eop;
    logic [3:0]    dst_x;
    logic [3:0]    dst_y;
    logic [PW-1:0] data;
  } entry_t;

  inj_state_e     state_q, state_d;
  logic [VCW-1:0] cur_vc_q, cur_vc_d;
  logic [VCW-1:0] last_vc_q, last_vc_d;
  logic [CRW-1:0] credit_q [NVCH];

  entry_t         wr_entry;
  entry_t         front;
  logic           fifo_push;
  logic           fifo_pop;
  logic           fifo_full;
  logic           fifo_empty;

  logic           issue;
  logic [VCW-1:0] issue_vc;
  logic [DATAW-1:0] issue_flit;
  logic           drop_word;
  logic [PW-1:0]  head_payload;
  logic [1:0]     data_type;

  logic           vc_found;
  logic [VCW-1:0] vc_pick;
  logic [VCW:0]   rr_sum;
  logic [NVCH-1:0] credit_inc;
  logic [NVCH-1:0] credit_dec;
  logic [NVCH-1:0] credit_full;

  assign core_ready = rst_ && !fifo_full;
  assign fifo_push  = core_valid && core_ready;
  assign wr_entry   = '{sop: core_sop, eop: core_eop, dst_x: core_dst_x,
                        dst_y: core_dst_y, data: core_data};

  ni_fifo #(
    .WIDTH ($bits(entry_t)),
    .DEPTH (FIFODEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_  (rst_),
    .push  (fifo_push),
    .wdata (wr_entry),
    .pop   (fifo_pop),
    .rdata (front),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_comb begin
    head_payload = '0;
    head_payload[HEAD_DSTX_LSB +: HEAD_FIELD_W] = front.dst_x;
    head_payload[HEAD_DSTY_LSB +: HEAD_FIELD_W] = front.dst_y;
    head_payload[HEAD_SRCX_LSB +: HEAD_FIELD_W] = HEAD_FIELD_W'(MY_XPOS);
    head_payload[HEAD_SRCY_LSB +: HEAD_FIELD_W] = HEAD_FIELD_W'(MY_YPOS);
    data_type = front.eop ? FLIT_TAIL : FLIT_BODY;
  end

  // Round-robin search from last_vc+1; only fully drained, unlocked VCs qualify.
  always_comb begin
    vc_found = 1'b0;
    vc_pick  = '0;
    rr_sum   = '0;
    for (int i = 1; i <= NVCH; i++) begin
      rr_sum = {1'b0, last_vc_q} + (VCW+1)'(i);
      if (rr_sum >= (VCW+1)'(NVCH)) rr_sum = rr_sum - (VCW+1)'(NVCH);
      if (!vc_found && !ilck[rr_sum[VCW-1:0]] &&
          credit_q[rr_sum[VCW-1:0]] == CRED_FULL) begin
        vc_found = 1'b1;
        vc_pick  = rr_sum[VCW-1:0];
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    cur_vc_d   = cur_vc_q;
    last_vc_d  = last_vc_q;
    fifo_pop   = 1'b0;
    issue      = 1'b0;
    issue_vc   = cur_vc_q;
    issue_flit = '0;
    drop_word  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          if (front.sop) begin
            // The head is synthesised from the sop entry, which stays queued as the first payload.
            if (vc_found) begin
              issue      = 1'b1;
              issue_vc   = vc_pick;
              issue_flit = {FLIT_HEAD, head_payload};
              cur_vc_d   = vc_pick;
              last_vc_d  = vc_pick;
              state_d    = ST_SEND;
            end
          end else begin
            fifo_pop  = 1'b1;
            drop_word = 1'b1;
          end
        end
      end
      ST_SEND: begin
        if (!fifo_empty && credit_q[cur_vc_q] != '0) begin
          fifo_pop   = 1'b1;
          issue      = 1'b1;
          issue_flit = {data_type, front.data};
          if (front.eop) state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    credit_inc  = '0;
    credit_dec  = '0;
    credit_full = '0;
    for (int v = 0; v < NVCH; v++) begin
      credit_full[v] = (credit_q[v] == CRED_FULL);
      credit_inc[v]  = iack[v] && !credit_full[v];
      credit_dec[v]  = issue && (issue_vc == VCW'(v));
    end
  end

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      state_q   <= ST_IDLE;
      cur_vc_q  <= '0;
      last_vc_q <= VCW'(NVCH - 1);
    end else begin
      state_q   <= state_d;
      cur_vc_q  <= cur_vc_d;
      last_vc_q <= last_vc_d;
    end
  end

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      for (int v = 0; v < NVCH; v++) credit_q[v] <= CRED_FULL;
    end else begin
      for (int v = 0; v < NVCH; v++) begin
        if (credit_inc[v] && !credit_dec[v])      credit_q[v] <= credit_q[v] + CRW'(1);
        else if (!credit_inc[v] && credit_dec[v]) credit_q[v] <= credit_q[v] - CRW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      odata  <= '0;
      ovalid <= 1'b0;
      ovch   <= '0;
    end else begin
      ovalid <= issue;
      odata  <= issue ? issue_flit : '0;
      ovch   <= issue ? issue_vc : '0;
    end
  end

  // Credit return on a full VC and payload without a head are upstream protocol faults.
  always @(posedge clk) begin
    if (rst_) begin
      assert (ROUTERID >= 0 && MY_XPOS < 16 && MY_YPOS < 16);
      assert ((iack & credit_full) == '0);
      assert (!drop_word);
    end
  end

endmodule

// File: tb/tb_ni_inject.sv
// tb/tb_ni_inject.sv - self-checking bench for ni_inject: flit scoreboard, VC/credit model, directed scenarios
module tb_ni_inject;

  localparam int DATAW     = 64;
  localparam int NVCH      = 2;
  localparam int BUFDEPTH  = 4;
  localparam int FIFODEPTH = 4;
  localparam int MY_XPOS   = 1;
  localparam int MY_YPOS   = 0;
  localparam int PW        = DATAW - 2;

  logic             clk = 1'b0;
  logic             rst_ = 1'b0;
  logic [PW-1:0]    core_data = '0;
  logic             core_sop = 1'b0;
  logic             core_eop = 1'b0;
  logic [3:0]       core_dst_x = '0;
  logic [3:0]       core_dst_y = '0;
  logic             core_valid = 1'b0;
  logic             core_ready;
  logic [DATAW-1:0] odata;
  logic             ovalid;
  logic [0:0]       ovch;
  logic [NVCH-1:0]  iack_auto = '0;
  logic [NVCH-1:0]  iack_man = '0;
  logic [NVCH-1:0]  ilck = '0;
  logic [NVCH-1:0]  iack;
  logic             auto_ack = 1'b0;

  assign iack = iack_auto | iack_man;

  ni_inject #(
    .ROUTERID  (0),
    .MY_XPOS   (MY_XPOS),
    .MY_YPOS   (MY_YPOS),
    .DATAW     (DATAW),
    .NVCH      (NVCH),
    .BUFDEPTH  (BUFDEPTH),
    .FIFODEPTH (FIFODEPTH)
  ) dut (
    .clk        (clk),
    .rst_       (rst_),
    .core_data  (core_data),
    .core_sop   (core_sop),
    .core_eop   (core_eop),
    .core_dst_x (core_dst_x),
    .core_dst_y (core_dst_y),
    .core_valid (core_valid),
    .core_ready (core_ready),
    .odata      (odata),
    .ovalid     (ovalid),
    .ovch       (ovch),
    .iack       (iack),
    .ilck       (ilck)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int n_checks = 0;
  int n_fail   = 0;

  logic [DATAW-1:0] exp_q[$];
  int               head_vcs[$];
  int               credit_m [NVCH];
  int               last_m = NVCH - 1;
  int               cur_m = 0;
  logic [NVCH-1:0]  prev_iack = '0;
  logic [NVCH-1:0]  prev_ilck = '0;
  int               flit_count = 0;
  int               pkt_flits = 0;
  int               sop_cyc = 0;
  int               head_lat = -1;
  logic [DATAW-1:0] last_head = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [DATAW-1:0] head_of(input logic [3:0] dx, input logic [3:0] dy);
    logic [DATAW-1:0] h;
    h = '0;
    h[DATAW-1 -: 2] = 2'b01;
    h[3:0]   = dx;
    h[7:4]   = dy;
    h[11:8]  = 4'(MY_XPOS);
    h[15:12] = 4'(MY_YPOS);
    return h;
  endfunction

  function automatic int hv(input int i);
    return (i < head_vcs.size()) ? head_vcs[i] : -1;
  endfunction

  // Scoreboard and credit/VC model, evaluated mid-cycle away from the active edge.
  always @(negedge clk) begin
    logic [DATAW-1:0] e;
    int pred;
    if (!rst_) begin
      check("reset_odata", odata, 0);
      check("reset_ovalid", ovalid, 0);
      check("reset_ovch", ovch, 0);
      check("reset_core_ready", core_ready, 0);
      exp_q.delete();
      for (int v = 0; v < NVCH; v++) credit_m[v] = BUFDEPTH;
      last_m = NVCH - 1;
      cur_m = 0;
      prev_iack = '0;
      prev_ilck = ilck;
    end else begin
      if (ovalid) begin
        flit_count++;
        pkt_flits++;
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_flit: got %0h with no flit expected", odata);
        end else begin
          e = exp_q.pop_front();
          check("flit_data", odata, e);
          if (e[DATAW-1 -: 2] == 2'b01) begin
            pred = -1;
            for (int i = 1; i <= NVCH; i++) begin
              int v;
              v = (last_m + i) % NVCH;
              if (pred < 0 && !prev_ilck[v] && credit_m[v] == BUFDEPTH) pred = v;
            end
            check("head_vc", ovch, pred);
            last_m = int'(ovch);
            cur_m = int'(ovch);
            pkt_flits = 1;
            head_vcs.push_back(int'(ovch));
            head_lat = cyc - sop_cyc;
            last_head = odata;
          end else begin
            check("body_vc", ovch, cur_m);
            check("credit_available", credit_m[cur_m] > 0, 1);
          end
        end
      end
      for (int v = 0; v < NVCH; v++) begin
        if (prev_iack[v] && credit_m[v] < BUFDEPTH) credit_m[v]++;
        if (ovalid && int'(ovch) == v) credit_m[v]--;
      end
      prev_iack = iack;
      prev_ilck = ilck;
      if (core_valid && core_ready) begin
        if (core_sop) begin
          exp_q.push_back(head_of(core_dst_x, core_dst_y));
          sop_cyc = cyc;
        end
        exp_q.push_back({core_eop ? 2'b10 : 2'b00, core_data});
      end
    end
  end

  // Router that forwards every flit immediately and returns its credit the same cycle.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (auto_ack && rst_ && ovalid) iack_auto = NVCH'(1) << ovch;
      else iack_auto = '0;
    end
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_pkt(input int n, input logic [3:0] dx, input logic [3:0] dy,
                          input logic [PW-1:0] base);
    int  t;
    bit  acc;
    for (int i = 0; i < n; i++) begin
      core_valid = 1'b1;
      core_sop   = (i == 0);
      core_eop   = (i == n - 1);
      core_dst_x = dx;
      core_dst_y = dy;
      core_data  = base + PW'(i);
      acc = 1'b0;
      t = 0;
      while (!acc && t < 200) begin
        @(negedge clk);
        if (!rst_) t = 1000;
        else if (core_ready) acc = 1'b1;
        else t++;
      end
      if (!rst_) begin
        core_valid = 1'b0;
        return;
      end
      if (!acc) begin
        n_checks++;
        n_fail++;
        $display("FAIL send_timeout: word %0d never accepted", i);
        core_valid = 1'b0;
        return;
      end
      @(posedge clk);
      #1;
    end
    core_valid = 1'b0;
    core_sop   = 1'b0;
    core_eop   = 1'b0;
  endtask

  task automatic wait_empty(input string name);
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 300) begin
      @(posedge clk);
      #1;
      t++;
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL %s: %0d flits still outstanding, required 0", name, exp_q.size());
    end
    wait_cyc(3);
  endtask

  task automatic pulse_ack(input int v);
    iack_man = NVCH'(1) << v;
    @(posedge clk);
    #1;
    iack_man = '0;
    @(posedge clk);
    #1;
  endtask

  task automatic drain_all();
    int t;
    for (int v = 0; v < NVCH; v++) begin
      t = 0;
      while (credit_m[v] < BUFDEPTH && t < 40) begin
        pulse_ack(v);
        t++;
      end
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    rst_ = 1'b1;
    @(negedge clk);
    check("ready_after_reset", core_ready, 1);
    @(posedge clk);
    #1;

    // Single 3-word packet, dst (2,1) from (1,0).
    auto_ack = 1'b1;
    head_vcs.delete();
    send_pkt(3, 4'd2, 4'd1, 62'h100);
    wait_empty("t2_drain");
    check("t2_head_latency", head_lat, 2);
    check("t2_head_data", last_head, 64'h4000_0000_0000_0112);
    check("t2_head_vc", hv(0), 0);
    check("t2_flit_count", pkt_flits, 4);

    // Back-to-back packets rotate VCs.
    head_vcs.delete();
    send_pkt(2, 4'd3, 4'd3, 62'h200);
    send_pkt(2, 4'd4, 4'd0, 62'h300);
    send_pkt(2, 4'd0, 4'd5, 62'h400);
    wait_empty("t3_drain");
    check("t3_num_heads", head_vcs.size(), 3);
    check("t3_vc_a", hv(0), 1);
    check("t3_vc_b", hv(1), 0);
    check("t3_vc_c", hv(2), 1);

    // Locked VC 0 is skipped; single-word packet is head then tail.
    drain_all();
    ilck = 2'b01;
    head_vcs.delete();
    send_pkt(1, 4'd3, 4'd2, 62'h500);
    wait_empty("t4_drain");
    check("t4_head_vc", hv(0), 1);
    check("t4_head_data", last_head, 64'h4000_0000_0000_0123);
    check("t4_flit_count", pkt_flits, 2);
    ilck = 2'b00;

    // No credit return: 4 flits then stall, one flit per returned credit.
    auto_ack = 1'b0;
    wait_cyc(2);
    drain_all();
    head_vcs.delete();
    send_pkt(6, 4'd1, 4'd1, 62'h600);
    wait_cyc(10);
    check("t5_head_vc", hv(0), 0);
    check("t5_stall_flits", pkt_flits, 4);
    for (int k = 1; k <= 3; k++) begin
      pulse_ack(0);
      wait_cyc(4);
      check("t5_release_flits", pkt_flits, 4 + k);
    end
    check("t5_all_sent", exp_q.size(), 0);
    drain_all();

    // Credit return coincident with a body issue on the same VC leaves the count unchanged.
    head_vcs.delete();
    fork
      send_pkt(6, 4'd5, 4'd6, 62'h700);
      begin : ack_on_head
        int t;
        t = 0;
        do begin
          @(posedge clk);
          #1;
          t++;
        end while (!(ovalid && odata[DATAW-1 -: 2] == 2'b01) && t < 50);
        iack_man = 2'b10;
        @(posedge clk);
        #1;
        iack_man = '0;
      end
    join
    wait_cyc(10);
    check("t6_head_vc", hv(0), 1);
    check("t6_stall_flits", pkt_flits, 5);
    pulse_ack(1);
    pulse_ack(1);
    wait_cyc(4);
    check("t6_final_flits", pkt_flits, 7);
    drain_all();

    // Reset mid-packet with credits consumed; the next packet starts clean on VC 0.
    head_vcs.delete();
    fork
      send_pkt(6, 4'd7, 4'd7, 62'h800);
    join_none
    wait_cyc(4);
    rst_ = 1'b0;
    wait_cyc(2);
    rst_ = 1'b1;
    wait_cyc(2);
    auto_ack = 1'b1;
    head_vcs.delete();
    send_pkt(2, 4'd4, 4'd3, 62'h900);
    wait_empty("t7_drain");
    check("t7_head_vc", hv(0), 0);
    check("t7_head_data", last_head, 64'h4000_0000_0000_0134);
    check("t7_flit_count", pkt_flits, 3);
    check("t7_head_latency", head_lat, 2);

    wait_cyc(5);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
